alu_serial_seq: RTL and testbench
=================================

Name: alu_serial_seq

Overview:
- Bit-serial sequencer that time-shares one external 1-bit ALU slice (AND/OR/ADD/SUB/SLT, bInvert, carry in/out) to compute a full WIDTH-bit operation, LSB first, one bit per clock.
- Sits beside the EX stage as a low-area ALU alternative for multi-cycle ops.
- Owns operand/result shift registers, the carry flop, the start/busy/done handshake and the SLT post-fixup.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).
- CNT_W, $clog2(WIDTH), bit-counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; other codes treated as ADD.
- a  in  WIDTH  operand A, captured on accepted start.
- b  in  WIDTH  operand B, captured on accepted start.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse; result valid.
- result  out  WIDTH  held until the next accepted start.
- zero  out  1  result==0, registered with result.
- slice_a  out  1  A bit to slice.
- slice_b  out  1  B bit to slice.
- slice_cin  out  1  carry-in to slice.
- slice_binv  out  1  bInvert to slice.
- slice_ctl  out  3  slice control: AND 000, OR 001, else 010.
- slice_sum  in  1  slice result bit (combinational from the slice_* outputs).
- slice_cout  in  1  slice carry-out.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0; done=0; result=0; zero=0; carry=0; count=0; all slice_* outputs = 0.
- States:
  - IDLE: start=1 captures a, b, op into shift regs; sets carry = (op==SUB or SLT); count=0; goes to RUN. start=0 stays IDLE.
  - RUN, each cycle:
    - slice_a = a_sh[0], slice_b = b_sh[0], slice_cin = carry.
    - slice_binv = 1 for SUB/SLT, else 0.
    - On clock edge: result_sh shifts right with slice_sum entering MSB; carry <= slice_cout; a_sh and b_sh shift right.
    - In the MSB cycle (count==WIDTH-1), also capture msb_cin=carry and msb_sum=slice_sum.
    - count increments; on count==WIDTH-1 go to SLT_FIX if op==SLT, else DONE.
  - SLT_FIX (1 cycle): result = {WIDTH-1 zeros, less}. less = msb_sum XOR ovf, where ovf = msb_cin XOR carry. Then go to DONE.
  - DONE (1 cycle): done=1, result and zero registered; then IDLE.
- Outputs and latency:
  - busy=1 in RUN, SLT_FIX and DONE.
  - slice_* outputs = 0 outside RUN.
  - Latency from accepted start to done: WIDTH+1 cycles, or WIDTH+2 for SLT.
  - Back-to-back: start may be accepted in the IDLE cycle right after DONE.
- Boundary conditions:
  - start while busy: ignored, no queueing.
  - op/a/b changes during RUN: no effect.
  - Reset mid-operation: immediate abort to reset values; no done pulse.
- Arithmetic: two's complement; final carry discarded for ADD/SUB. SLT is a signed compare.

Optional Feature:
- Macro ALU_SERIAL_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), registered in DONE.
  - ovf = msb_cin XOR msb_cout for ADD/SUB; 0 for AND/OR/SLT.
  - Reset value 0; held with result.
- Undefined: no ovf port. The SLT fixup still computes overflow internally, so SLT remains correct.

Decomposition:
- Package alu_serial_pkg holds:
  - op encodings OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT (3 bits) and SLICE_CTL_ADD=3'b010;
  - state enum typedef {ST_IDLE, ST_RUN, ST_SLT_FIX, ST_DONE};
  - a function mapping op to {binv, cin0, slice_ctl}.
- The sequencer is one module.
- The bench instantiates the existing 1-bit slice externally and wires the slice_* ports to it; no new sub-module is needed.

Test Plan (WIDTH=32):
- ADD: a=0x0000_0005, b=0x0000_0003 -> done 33 cycles after the start edge, result=0x0000_0008, zero=0, busy high for exactly 33 cycles.
- SUB: a=5, b=5 -> result=0, zero=1. With ALU_SERIAL_OVF_EN: a=0x8000_0000, b=1 -> result=0x7FFF_FFFF, ovf=1.
- SLT: a=0xFFFF_FFFF (-1), b=1 -> result=1 after 34 cycles. a=0x7FFF_FFFF, b=0x8000_0000 -> result=0 (overflow-corrected).
- AND/OR: a=0xF0F0_F0F0, b=0xFF00_FF00 -> AND gives 0xF000_F000, OR gives 0xFFF0_FFF0; slice_ctl is 000/001 respectively during RUN.
- start pulses every cycle during busy, plus a new start in the IDLE cycle after done -> exactly one done per accepted op; the second op's result is correct.
- rst_n low at RUN count=10, high again -> all outputs at reset values, no done. The next ADD 1+1 returns 2.

Source files
------------

// File: rtl/alu_serial_pkg.sv
// Shared encodings, state type and op decode for the bit-serial ALU sequencer.
package alu_serial_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam logic [2:0] SLICE_CTL_AND = 3'b000;
    localparam logic [2:0] SLICE_CTL_OR  = 3'b001;
    localparam logic [2:0] SLICE_CTL_ADD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_SLT_FIX,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic       binv;
        logic       cin0;
        logic [2:0] ctl;
    } slice_cfg_t;

    // Unknown op codes collapse to ADD so the rest of the design sees only five ops.
    function automatic logic [2:0] op_norm(input logic [2:0] op);
        case (op)
            OP_AND, OP_OR, OP_SUB, OP_SLT: op_norm = op;
            default:                       op_norm = OP_ADD;
        endcase
    endfunction

    function automatic slice_cfg_t op_to_slice_cfg(input logic [2:0] op);
        slice_cfg_t cfg;
        cfg.binv = 1'b0;
        cfg.cin0 = 1'b0;
        cfg.ctl  = SLICE_CTL_ADD;
        case (op)
            OP_AND: cfg.ctl = SLICE_CTL_AND;
            OP_OR:  cfg.ctl = SLICE_CTL_OR;
            OP_SUB, OP_SLT: begin
                cfg.binv = 1'b1;
                cfg.cin0 = 1'b1;
            end
            default: cfg.ctl = SLICE_CTL_ADD;
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer driving an external 1-bit ALU slice, LSB first.
// Optional ALU_SERIAL_OVF_EN adds a registered signed-overflow output.
module alu_serial_seq
    import alu_serial_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
`ifdef ALU_SERIAL_OVF_EN
    output logic             ovf,
`endif
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic             slice_binv,
    output logic [2:0]       slice_ctl,
    input  logic             slice_sum,
    input  logic             slice_cout
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_sh_q, res_sh_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2:0]         op_q, op_d;
    logic               carry_q, carry_d;
    logic               msb_cin_q, msb_cin_d;
    logic               msb_sum_q, msb_sum_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               zero_q, zero_d;
    logic               slice_cin_q, slice_cin_d;
    logic               slice_binv_q, slice_binv_d;
    logic [2:0]         slice_ctl_q, slice_ctl_d;
`ifdef ALU_SERIAL_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic [2:0]         op_in;
    slice_cfg_t         cfg_in;
    slice_cfg_t         cfg_next;
    logic               run_next;

    always_comb begin
        state_d      = state_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        res_sh_d     = res_sh_q;
        result_d     = result_q;
        count_d      = count_q;
        op_d         = op_q;
        carry_d      = carry_q;
        msb_cin_d    = msb_cin_q;
        msb_sum_d    = msb_sum_q;
        done_d       = 1'b0;
        zero_d       = zero_q;
`ifdef ALU_SERIAL_OVF_EN
        ovf_d        = ovf_q;
`endif
        op_in        = op_norm(op);
        cfg_in       = op_to_slice_cfg(op_in);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    op_d    = op_in;
                    carry_d = cfg_in.cin0;
                    count_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Zero-fill keeps slice_a/slice_b low once all bits are consumed.
                res_sh_d = {slice_sum, res_sh_q[WIDTH-1:1]};
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d  = slice_cout;
                count_d  = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    msb_cin_d = carry_q;
                    msb_sum_d = slice_sum;
                    state_d   = (op_q == OP_SLT) ? ST_SLT_FIX : ST_DONE;
                end
            end
            ST_SLT_FIX: begin
                // Signed less-than: sign of the difference corrected by overflow.
                res_sh_d = {{(WIDTH-1){1'b0}}, msb_sum_q ^ msb_cin_q ^ carry_q};
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                done_d   = 1'b1;
                result_d = res_sh_q;
                zero_d   = (res_sh_q == '0);
`ifdef ALU_SERIAL_OVF_EN
                ovf_d    = ((op_q == OP_ADD) || (op_q == OP_SUB)) ? (msb_cin_q ^ carry_q) : 1'b0;
`endif
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d       = (state_d != ST_IDLE);
        run_next     = (state_d == ST_RUN);
        cfg_next     = op_to_slice_cfg(op_d);
        slice_cin_d  = run_next ? carry_d       : 1'b0;
        slice_binv_d = run_next ? cfg_next.binv : 1'b0;
        slice_ctl_d  = run_next ? cfg_next.ctl  : 3'b000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            res_sh_q     <= '0;
            result_q     <= '0;
            count_q      <= '0;
            op_q         <= OP_AND;
            carry_q      <= 1'b0;
            msb_cin_q    <= 1'b0;
            msb_sum_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            zero_q       <= 1'b0;
            slice_cin_q  <= 1'b0;
            slice_binv_q <= 1'b0;
            slice_ctl_q  <= 3'b000;
`ifdef ALU_SERIAL_OVF_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            res_sh_q     <= res_sh_d;
            result_q     <= result_d;
            count_q      <= count_d;
            op_q         <= op_d;
            carry_q      <= carry_d;
            msb_cin_q    <= msb_cin_d;
            msb_sum_q    <= msb_sum_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            zero_q       <= zero_d;
            slice_cin_q  <= slice_cin_d;
            slice_binv_q <= slice_binv_d;
            slice_ctl_q  <= slice_ctl_d;
`ifdef ALU_SERIAL_OVF_EN
            ovf_q        <= ovf_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign zero       = zero_q;
    assign slice_a    = a_sh_q[0];
    assign slice_b    = b_sh_q[0];
    assign slice_cin  = slice_cin_q;
    assign slice_binv = slice_binv_q;
    assign slice_ctl  = slice_ctl_q;
`ifdef ALU_SERIAL_OVF_EN
    assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq with a behavioural 1-bit ALU slice attached.
module tb_alu_serial_seq;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             slice_a;
    logic             slice_b;
    logic             slice_cin;
    logic             slice_binv;
    logic [2:0]       slice_ctl;
    logic             slice_sum;
    logic             slice_cout;
`ifdef ALU_SERIAL_OVF_EN
    logic             ovf;
`endif

    int n_checks;
    int n_errors;

    logic [WIDTH-1:0] r_res;
    logic             r_zero;
    int               r_lat;
    int               r_busy;
    logic [2:0]       r_ctl;
    logic             r_binv;
    logic             r_done_after;
    logic [7:0]       r_slice_idle;
    logic             r_ovf;

    alu_serial_seq #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .zero       (zero),
`ifdef ALU_SERIAL_OVF_EN
        .ovf        (ovf),
`endif
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_binv (slice_binv),
        .slice_ctl  (slice_ctl),
        .slice_sum  (slice_sum),
        .slice_cout (slice_cout)
    );

    // Classic MIPS-style 1-bit slice; SLT uses the adder path, fixed up by the sequencer.
    logic bb;
    always_comb begin
        bb         = slice_b ^ slice_binv;
        slice_cout = (slice_a & bb) | (slice_a & slice_cin) | (bb & slice_cin);
        case (slice_ctl)
            3'b000:  slice_sum = slice_a & bb;
            3'b001:  slice_sum = slice_a | bb;
            default: slice_sum = slice_a ^ bb ^ slice_cin;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start  = 1'b0;
        op     = 3'($urandom_range(0, 7));
        a      = $urandom;
        b      = $urandom;
        r_ctl  = slice_ctl;
        r_binv = slice_binv;
        r_busy = int'(busy);
        r_lat  = 0;
        while (r_lat < 100) begin
            @(posedge clk);
            #1;
            r_lat++;
            r_busy += int'(busy);
            if (done) break;
        end
        r_res        = result;
        r_zero       = zero;
        r_slice_idle = {slice_a, slice_b, slice_cin, slice_binv, slice_ctl, busy};
`ifdef ALU_SERIAL_OVF_EN
        r_ovf        = ovf;
`else
        r_ovf        = 1'b0;
`endif
        @(posedge clk);
        #1;
        r_done_after = done;
    endtask

    initial begin
        int ndone;
        int lat;
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        op       = 3'b000;
        a        = '0;
        b        = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", 32'({busy, done, zero, slice_a, slice_b, slice_cin, slice_binv, slice_ctl}), 32'h0);
        check("reset_result", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD with latency and busy-length checks
        do_op(3'b010, 32'h0000_0005, 32'h0000_0003);
        check("add_res", r_res, 32'h0000_0008);
        check("add_zero", 32'(r_zero), 32'h0);
        check("add_lat", 32'(r_lat), 32'd33);
        check("add_busy_cycles", 32'(r_busy), 32'd33);
        check("add_done_pulse", 32'(r_done_after), 32'h0);
        check("add_slice_idle", 32'(r_slice_idle), 32'h0);
        check("add_binv", 32'(r_binv), 32'h0);
        check("add_ctl", 32'(r_ctl), 32'h2);
`ifdef ALU_SERIAL_OVF_EN
        check("add_ovf", 32'(r_ovf), 32'h0);
`endif

        do_op(3'b011, 32'h0000_0005, 32'h0000_0003);
        check("undef_op_as_add", r_res, 32'h0000_0008);

        do_op(3'b110, 32'd5, 32'd5);
        check("sub_res", r_res, 32'h0);
        check("sub_zero", 32'(r_zero), 32'h1);
        check("sub_lat", 32'(r_lat), 32'd33);
        check("sub_binv", 32'(r_binv), 32'h1);

        do_op(3'b110, 32'h8000_0000, 32'h0000_0001);
        check("sub_wrap_res", r_res, 32'h7FFF_FFFF);
`ifdef ALU_SERIAL_OVF_EN
        check("sub_wrap_ovf", 32'(r_ovf), 32'h1);
`endif

        do_op(3'b111, 32'hFFFF_FFFF, 32'h0000_0001);
        check("slt_neg_res", r_res, 32'h1);
        check("slt_neg_lat", 32'(r_lat), 32'd34);
        check("slt_neg_busy_cycles", 32'(r_busy), 32'd34);

        do_op(3'b111, 32'h7FFF_FFFF, 32'h8000_0000);
        check("slt_ovf_res", r_res, 32'h0);
        check("slt_ovf_zero", 32'(r_zero), 32'h1);

        do_op(3'b111, 32'h8000_0000, 32'h7FFF_FFFF);
        check("slt_ovf_true_res", r_res, 32'h1);

        do_op(3'b111, 32'd5, 32'd5);
        check("slt_equal_res", r_res, 32'h0);

        do_op(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00);
        check("and_res", r_res, 32'hF000_F000);
        check("and_ctl", 32'(r_ctl), 32'h0);
        check("and_lat", 32'(r_lat), 32'd33);

        do_op(3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00);
        check("or_res", r_res, 32'hFFF0_FFF0);
        check("or_ctl", 32'(r_ctl), 32'h1);

        // start held high through busy and into the IDLE cycle after done
        @(negedge clk);
        start = 1'b1;
        op    = 3'b010;
        a     = 32'h0000_0005;
        b     = 32'h0000_0003;
        @(posedge clk);
        #1;
        op    = 3'b001;
        a     = 32'h0000_0100;
        b     = 32'h0000_0200;
        lat   = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
        check("b2b_first_lat", 32'(lat), 32'd33);
        check("b2b_first_res", result, 32'h0000_0008);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_accept_busy", 32'(busy), 32'h1);
        check("b2b_no_second_done", 32'(done), 32'h0);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
        check("b2b_second_lat", 32'(lat), 32'd33);
        check("b2b_second_res", result, 32'h0000_0300);

        // reset asserted mid-operation
        @(negedge clk);
        start = 1'b1;
        op    = 3'b010;
        a     = 32'h0000_1234;
        b     = 32'h0000_0001;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctrl", 32'({busy, done, zero, slice_a, slice_b, slice_cin, slice_binv, slice_ctl}), 32'h0);
        check("rst_mid_result", result, 32'h0);
        ndone = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            ndone += int'(done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            ndone += int'(done) + int'(busy);
        end
        check("rst_no_done", 32'(ndone), 32'h0);

        do_op(3'b010, 32'd1, 32'd1);
        check("post_rst_add", r_res, 32'd2);
        check("post_rst_lat", 32'(r_lat), 32'd33);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
